// File: rtl/jesd204_versal_gt_pkg.sv
// Shared constants, types and helpers for the JESD204 Versal GT TX adapter.
// Used by the gearbox sequencer and the adapter top level.
package jesd204_versal_gt_pkg;

  localparam int LINK_MODE_8B10B  = 1;
  localparam int LINK_MODE_64B66B = 2;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

  localparam int GT_TXDATA_W = 128;
  localparam int GT_TXSEQ_W  = 7;

  typedef struct packed {
    logic [GT_TXDATA_W-1:0] data;
    logic [5:0]             header;
    logic [GT_TXSEQ_W-1:0]  seq;
    logic [7:0]             ctrl2;
  } gt_tx_t;

  function automatic logic [63:0] bit_rev64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[63-i] = d[i];
    end
    return r;
  endfunction

  function automatic logic hdr_valid(input logic [1:0] h);
    return (h == SYNC_HDR_DATA) || (h == SYNC_HDR_CTRL);
  endfunction

endpackage

// File: rtl/jesd204_tx_gearbox_seq.sv
// TX gearbox sequence counter for 64B66B mode.
// Pauses the link layer on the terminal count of each gearbox period.
module jesd204_tx_gearbox_seq
  import jesd204_versal_gt_pkg::*;
#(
  parameter int SEQ_MAX = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output logic [GT_TXSEQ_W-1:0] seq_cnt_o,
  output logic                  tx_ready_o
);

  localparam logic [GT_TXSEQ_W-1:0] SEQ_LAST = GT_TXSEQ_W'(SEQ_MAX);

  logic [GT_TXSEQ_W-1:0] seq_cnt_q;
  logic [GT_TXSEQ_W-1:0] seq_cnt_d;

  always_comb begin
    seq_cnt_d = seq_cnt_q + 7'd1;
    if (seq_cnt_q == SEQ_LAST) begin
      seq_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      seq_cnt_q <= '0;
    end else begin
      seq_cnt_q <= seq_cnt_d;
    end
  end

  assign seq_cnt_o  = seq_cnt_q;
  assign tx_ready_o = ~reset_i & (seq_cnt_q != SEQ_LAST);

endmodule

// File: rtl/jesd204_versal_gt_adapter_tx.sv
// Link-layer TX to Versal GT channel adapter, one instance per lane.
// 64B66B drives the synchronous gearbox; 8B10B is a registered pass-through.
module jesd204_versal_gt_adapter_tx
  import jesd204_versal_gt_pkg::*;
#(
  parameter int LINK_MODE = 2,
  parameter int SEQ_MAX   = 32
) (
  input  logic         usr_clk,
  input  logic         reset,
  input  logic [63:0]  tx_data,
  input  logic [3:0]   tx_charisk,
  input  logic [1:0]   tx_header,
  output logic         tx_ready,
  output logic [7:0]   tx_header_err_cnt,
  output logic [127:0] txdata,
  output logic [5:0]   txheader,
  output logic [6:0]   txsequence,
  output logic [15:0]  txctrl0,
  output logic [15:0]  txctrl1,
  output logic [7:0]   txctrl2
);

  gt_tx_t     out_q;
  gt_tx_t     out_d;
  logic [7:0] err_q;
  logic [7:0] err_d;
  logic       ready;

  // Each mode leaves some inputs unused.
  logic unused_in;
  assign unused_in = ^{tx_data, tx_header, tx_charisk};

  generate
    if (LINK_MODE == LINK_MODE_64B66B) begin : g_64b66b
      logic [GT_TXSEQ_W-1:0] seq_cnt;

      jesd204_tx_gearbox_seq #(
        .SEQ_MAX(SEQ_MAX)
      ) u_seq (
        .clk_i     (usr_clk),
        .reset_i   (reset),
        .seq_cnt_o (seq_cnt),
        .tx_ready_o(ready)
      );

      // Data/header hold through the pause; the GT ignores them then.
      always_comb begin
        out_d       = out_q;
        err_d       = err_q;
        out_d.seq   = seq_cnt;
        out_d.ctrl2 = '0;
        if (ready) begin
          out_d.data   = {64'b0, bit_rev64(tx_data)};
          out_d.header = {4'b0, tx_header[0], tx_header[1]};
          if (!hdr_valid(tx_header) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
        end
      end
    end else begin : g_8b10b
      assign ready = ~reset;

      always_comb begin
        out_d       = '0;
        out_d.data  = {96'b0, tx_data[31:0]};
        out_d.ctrl2 = {4'b0, tx_charisk};
        err_d       = '0;
      end
    end
  endgenerate

  always_ff @(posedge usr_clk) begin
    if (reset) begin
      out_q <= '0;
      err_q <= '0;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign tx_ready          = ready;
  assign tx_header_err_cnt = err_q;
  assign txdata            = out_q.data;
  assign txheader          = out_q.header;
  assign txsequence        = out_q.seq;
  assign txctrl0           = '0;
  assign txctrl1           = '0;
  assign txctrl2           = out_q.ctrl2;

endmodule

// File: tb/tb_jesd204_versal_gt_adapter_tx.sv
// Scoreboard bench: one 64B66B and one 8B10B adapter driven by shared stimulus,
// checked each cycle against a cycle-count reference model.
module tb_jesd204_versal_gt_adapter_tx;

  localparam int SEQ_MAX = 32;
  localparam int PER     = SEQ_MAX + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] d;
  logic [1:0]  h;
  logic [3:0]  k;

  logic         rdy_a, rdy_b;
  logic [7:0]   err_a, err_b;
  logic [127:0] dat_a, dat_b;
  logic [5:0]   hdr_a, hdr_b;
  logic [6:0]   seq_a, seq_b;
  logic [15:0]  c0_a, c0_b, c1_a, c1_b;
  logic [7:0]   c2_a, c2_b;

  jesd204_versal_gt_adapter_tx #(.LINK_MODE(2), .SEQ_MAX(SEQ_MAX)) dut_a (
    .usr_clk(clk), .reset(rst), .tx_data(d), .tx_charisk(k),
    .tx_header(h), .tx_ready(rdy_a), .tx_header_err_cnt(err_a),
    .txdata(dat_a), .txheader(hdr_a), .txsequence(seq_a),
    .txctrl0(c0_a), .txctrl1(c1_a), .txctrl2(c2_a)
  );

  jesd204_versal_gt_adapter_tx #(.LINK_MODE(1), .SEQ_MAX(SEQ_MAX)) dut_b (
    .usr_clk(clk), .reset(rst), .tx_data(d), .tx_charisk(k),
    .tx_header(h), .tx_ready(rdy_b), .tx_header_err_cnt(err_b),
    .txdata(dat_b), .txheader(hdr_b), .txsequence(seq_b),
    .txctrl0(c0_b), .txctrl1(c1_b), .txctrl2(c2_b)
  );

  typedef struct {
    logic         rdy;
    logic [127:0] dat;
    logic [5:0]   hdr;
    logic [6:0]   seq;
    logic [7:0]   err;
    logic         rdy8;
    logic [127:0] dat8;
    logic [7:0]   c28;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: registered outputs plus cycles since reset release.
  int           t;
  logic [127:0] m_dat, m_dat8;
  logic [5:0]   m_hdr;
  logic [6:0]   m_seq;
  logic [7:0]   m_err, m_c28;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  function automatic logic [63:0] rev(input logic [63:0] x);
    return {<<{x}};
  endfunction

  function automatic logic [1:0] vhdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Drive one cycle; called just after a rising edge.
  task automatic step(input logic r, input logic [63:0] dd,
                      input logic [1:0] hh, input logic [3:0] kk);
    exp_t e;
    rst = r; d = dd; h = hh; k = kk;
    e.rdy  = !r && ((t % PER) != SEQ_MAX);
    e.dat  = m_dat;
    e.hdr  = m_hdr;
    e.seq  = m_seq;
    e.err  = m_err;
    e.rdy8 = !r;
    e.dat8 = m_dat8;
    e.c28  = m_c28;
    q.push_back(e);
    if (r) begin
      m_dat = '0; m_hdr = '0; m_seq = '0; m_err = '0;
      m_dat8 = '0; m_c28 = '0;
      t = 0;
    end else begin
      if (e.rdy) begin
        m_dat = {64'b0, rev(dd)};
        m_hdr = {4'b0, hh[0], hh[1]};
        if ((hh == 2'b00 || hh == 2'b11) && m_err < 8'd255) m_err++;
      end
      m_seq  = 7'(t % PER);
      m_dat8 = {96'b0, dd[31:0]};
      m_c28  = {4'b0, kk};
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ready64", rdy_a, e.rdy);
      chk("txdata64", dat_a, e.dat);
      chk("txheader64", hdr_a, e.hdr);
      chk("txseq64", seq_a, e.seq);
      chk("errcnt64", err_a, e.err);
      chk("ctrl64", {c0_a, c1_a, c2_a}, 0);
      chk("ready8", rdy_b, e.rdy8);
      chk("txdata8", dat_b, e.dat8);
      chk("txctrl2_8", c2_b, e.c28);
      chk("zero8", {c0_b, c1_b, hdr_b, seq_b, err_b}, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] err_hold;
    int g;
    rst = 1'b1; d = '0; h = '0; k = '0;
    t = 0;
    m_dat = '0; m_hdr = '0; m_seq = '0; m_err = '0;
    m_dat8 = '0; m_c28 = '0;
    @(posedge clk);
    #1;

    repeat (3) step(1'b1, r64(), 2'($urandom), 4'($urandom));
    chk("rst_ready", rdy_a, 0);

    step(1'b0, 64'h1, 2'b01, 4'b0000);
    chk("dir_data64", dat_a, 128'h0000_0000_0000_0000_8000_0000_0000_0000);
    chk("dir_hdr64", hdr_a, 6'b000010);
    chk("dir_seq64", seq_a, 0);

    step(1'b0, {32'h0, 32'hBC1C_5F3A}, 2'b10, 4'b1010);
    chk("dir_data8", dat_b, 128'hBC1C_5F3A);
    chk("dir_ctrl2", c2_b, 8'h0A);
    chk("dir_rdy8", rdy_b, 1);

    while (t < 100) begin
      if (t == 32 || t == 65 || t == 98) chk("pause_pos", rdy_a, 0);
      step(1'b0, r64(), vhdr(), 4'($urandom));
    end

    repeat (60) step(1'b0, r64(), 2'($urandom), 4'($urandom));

    err_hold = m_err;
    repeat (100) begin
      step(1'b0, r64(), ((t % PER) == SEQ_MAX) ? 2'b00 : vhdr(),
           4'($urandom));
    end
    chk("pause_err_hold", err_a, err_hold);

    g = 0;
    while ((t % PER) != 20 && g < 200) begin
      step(1'b0, r64(), vhdr(), 4'($urandom));
      g++;
    end
    step(1'b1, r64(), vhdr(), 4'($urandom));
    repeat (40) step(1'b0, r64(), vhdr(), 4'($urandom));

    step(1'b1, r64(), 2'b11, 4'($urandom));
    repeat (320) step(1'b0, r64(), 2'b11, 4'($urandom));
    chk("err_sat", err_a, 8'hFF);
    repeat (5) step(1'b0, r64(), 2'b00, 4'($urandom));
    chk("err_sat_hold", err_a, 8'hFF);

    @(negedge clk);
    #1;
    chk("sb_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
